mult_div_unit: RTL

//  Iterative multiply/divide unit with HI/LO result registers, placed downstream of the

---
 rtl/mult_div_unit.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
//
// MULT/MULTU use shift-add on operand magnitudes; DIV/DIVU use restoring division on
// magnitudes. Each takes WIDTH iteration cycles plus one fix-up cycle that applies the
// sign corrections and writes HI/LO. MTHI/MTLO write HI/LO directly in one cycle.
//
// Ports:
//   clk          clock, all state changes on posedge
//   rst          synchronous reset, active-high
//   start        operation request, sampled only while idle
//   op           000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO
//   opa          rs operand (multiplicand / dividend / MTHI-MTLO source)
//   opb          rt operand (multiplier / divisor)
//   busy         high while an operation is in flight
//   done         one-cycle pulse when hi/lo hold a new result
//   div_by_zero  one-cycle pulse with done for a divide by zero
//   hi           product upper half / remainder
//   lo           product lower half / quotient
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;   // negate product / quotient
    logic                 neg_rem_q, neg_rem_d;   // negate remainder
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     opa_lat_q, opa_lat_d;   // raw dividend, returned on divide by zero
    logic [WIDTH-1:0]     opnd_q, opnd_d;         // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    // Operand magnitudes at acceptance; unsigned ops never take the negate path.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // One iteration of each algorithm.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] rem_new;

    // Fix-up results.
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot_raw, rem_raw, quot, rem;

    always_comb begin
        a_neg = op[0] & opa[WIDTH-1];
        b_neg = op[0] & opb[WIDTH-1];
        a_mag = a_neg ? (~opa + 1'b1) : opa;
        b_mag = b_neg ? (~opb + 1'b1) : opb;

        // Multiply: add multiplicand into the upper half when the low bit is set, then
        // shift the whole accumulator right, keeping the carry as the new MSB.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

        // Divide: upper half is the partial remainder, lower half shifts the dividend
        // out of its MSB while quotient bits shift in at the LSB.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        rem_new   = div_ge ? div_diff : div_shift[WIDTH-1:0];

        product  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quot_raw = acc_q[WIDTH-1:0];
        rem_raw  = acc_q[2*WIDTH-1:WIDTH];
        quot     = neg_res_q ? (~quot_raw + 1'b1) : quot_raw;
        rem      = neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        opa_lat_d  = opa_lat_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            state_d    = StRun;
                            cnt_d      = '0;
                            is_div_d   = op[1];
                            neg_res_d  = a_neg ^ b_neg;
                            neg_rem_d  = a_neg;
                            div_zero_d = op[1] & (opb == '0);
                            opa_lat_d  = opa;
                            opnd_d     = op[1] ? b_mag : a_mag;
                            acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        end
                        3'b100: begin
                            hi_d   = opa;
                            done_d = 1'b1;
                        end
                        3'b101: begin
                            lo_d   = opa;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (is_div_q) begin
                    acc_d = {rem_new, acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                cnt_d   = '0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (div_zero_q) begin
                        lo_d  = '1;
                        hi_d  = opa_lat_q;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    hi_d = product[2*WIDTH-1:WIDTH];
                    lo_d = product[WIDTH-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            opa_lat_q  <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            opa_lat_q  <= opa_lat_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
